// File: rtl/key_debounce.sv
// Debouncer for active-low pushbuttons and active-high slide switches: two-flop
// synchronizers, per-bit saturating run counters, registered edge pulses.
module key_debounce #(
  parameter int unsigned CNT_MAX = 500000,
  parameter int unsigned NKEY    = 2,
  parameter int unsigned NSW     = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NKEY-1:0] key_n,
  input  logic [NSW-1:0]  sw,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [NSW-1:0]  sw_level,
  output logic            sw_change
);

  localparam int unsigned NB = NKEY + NSW;
  localparam int unsigned CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [NKEY-1:0] key_meta_q, key_sync_q;
  logic [NSW-1:0]  sw_meta_q,  sw_sync_q;

  logic [NB-1:0]   samp;
  logic [NB-1:0]   stable_q, stable_d;
  logic [NB-1:0]   accept;
  logic [CW-1:0]   cnt_q [NB];
  logic [CW-1:0]   cnt_d [NB];

  logic [NKEY-1:0] press_q, press_d;
  logic [NKEY-1:0] release_q, release_d;
  logic            change_q, change_d;

  // Keys reset to the released level so the first synchronized sample matches stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_q <= '1;
      key_sync_q <= '1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Keys occupy the low bits, switches the high bits; keys become active-high here.
  assign samp = {sw_sync_q, ~key_sync_q};

  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = samp[i];
        cnt_d[i]    = '0;
        accept[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    press_d   = accept[NKEY-1:0] &  stable_d[NKEY-1:0];
    release_d = accept[NKEY-1:0] & ~stable_d[NKEY-1:0];
    change_d  = |accept[NB-1:NKEY];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      change_q  <= 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      change_q  <= change_d;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_level   = stable_q[NKEY-1:0];
  assign sw_level    = stable_q[NB-1:NKEY];
  assign key_press   = press_q;
  assign key_release = release_q;
  assign sw_change   = change_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with CNT_MAX=4: stimulus queues expected
// pulse events, a negedge monitor pops and compares them as pulses appear.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic [9:0] sw;
  logic [1:0] key_level, key_press, key_release;
  logic [9:0] sw_level;
  logic       sw_change;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int          cyc;
    logic [16:0] val;
  } exp_t;

  exp_t q[$];
  exp_t me;
  logic [16:0] act;

  key_debounce #(.CNT_MAX(4), .NKEY(2), .NSW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .sw          (sw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .sw_level    (sw_level),
    .sw_change   (sw_change)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, a, e, cyc);
  endtask

  task automatic expect_ev(input int c, input logic [1:0] pr, input logic [1:0] rl,
                           input logic ch, input logic [1:0] kl, input logic [9:0] sl);
    exp_t e;
    e.cyc = c;
    e.val = {pr, rl, ch, kl, sl};
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the queue in cycle and value.
  always @(negedge clk) begin
    act = {key_press, key_release, sw_change, key_level, sw_level};
    if (|key_press || |key_release || sw_change) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got %h expected none (cycle %0d)", act, cyc);
      end else begin
        me = q.pop_front();
        chk("event_cycle", cyc, me.cyc);
        chk("event_value", {15'd0, act}, {15'd0, me.val});
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      me = q.pop_front();
      checks++;
      $display("FAIL missing_pulse: got none expected %h at cycle %0d (now %0d)", me.val, me.cyc, cyc);
    end
  end

  initial begin
    rst   = 1'b1;
    key_n = '1;
    sw    = '0;
    step(3);
    chk("rst_key_level",   {30'd0, key_level},   32'd0);
    chk("rst_key_press",   {30'd0, key_press},   32'd0);
    chk("rst_key_release", {30'd0, key_release}, 32'd0);
    chk("rst_sw_level",    {22'd0, sw_level},    32'd0);
    chk("rst_sw_change",   {31'd0, sw_change},   32'd0);
    rst = 1'b0;
    step(4);
    chk("post_rst_levels", {20'd0, key_level, sw_level}, 32'd0);

    // Press key 0: accepted on the 6th edge.
    key_n[0] = 1'b0;
    expect_ev(cyc + 6, 2'b01, 2'b00, 1'b0, 2'b01, 10'h000);
    step(10);
    chk("key1_untouched", {31'd0, key_level[1]}, 32'd0);

    // Release key 0.
    key_n[0] = 1'b1;
    expect_ev(cyc + 6, 2'b00, 2'b01, 1'b0, 2'b00, 10'h000);
    step(10);

    // Three-cycle glitch must be rejected.
    key_n[0] = 1'b0;
    step(3);
    key_n[0] = 1'b1;
    step(10);
    chk("glitch_level", {30'd0, key_level}, 32'd0);

    // Multi-bit switch change.
    sw = 10'h201;
    expect_ev(cyc + 6, 2'b00, 2'b00, 1'b1, 2'b00, 10'h201);
    step(10);

    // Interrupted run: high 2, low 1, then high held.
    sw[3] = 1'b1;
    step(2);
    sw[3] = 1'b0;
    step(1);
    sw[3] = 1'b1;
    expect_ev(cyc + 6, 2'b00, 2'b00, 1'b1, 2'b00, 10'h209);
    step(12);
    chk("sw_after_interrupt", {22'd0, sw_level}, 32'h209);

    // Simultaneous key and switch acceptance.
    key_n[1] = 1'b0;
    sw[5]    = 1'b1;
    expect_ev(cyc + 6, 2'b10, 2'b00, 1'b1, 2'b10, 10'h229);
    step(10);
    key_n[1] = 1'b1;
    expect_ev(cyc + 6, 2'b00, 2'b10, 1'b0, 2'b00, 10'h229);
    step(10);

    // Reset mid-count discards progress; held inputs re-accepted after release.
    key_n[1] = 1'b0;
    step(5);
    rst = 1'b1;
    step(2);
    chk("midcount_rst_outputs",
        {15'd0, key_press, key_release, sw_change, key_level, sw_level}, 32'd0);
    rst = 1'b0;
    expect_ev(cyc + 6, 2'b10, 2'b00, 1'b1, 2'b10, 10'h229);
    step(10);
    chk("final_key_level", {30'd0, key_level}, 32'h2);

    step(5);
    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CNT_MAX, default 500000, SHALL set the number of consecutive differing synchronized samples needed to accept a level change (10 ms at 50 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter NKEY, default 2, SHALL set the number of pushbutton inputs.
REQ-003 Parameter NSW, default 10, SHALL set the number of slide-switch inputs.
REQ-004 clk  input  1  SHALL be the single system clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 key_n  input  NKEY  SHALL carry the raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-007 sw  input  NSW  SHALL carry the raw asynchronous slide switches, active-high.
REQ-008 key_level  output  NKEY  SHALL be the debounced button state, active-high (1 = pressed).
REQ-009 key_press  output  NKEY  SHALL be a one-cycle pulse per bit on each accepted release-to-press transition.
REQ-010 key_release  output  NKEY  SHALL be a one-cycle pulse per bit on each accepted press-to-release transition.
REQ-011 sw_level  output  NSW  SHALL be the debounced switch state.
REQ-012 sw_change  output  1  SHALL be a one-cycle pulse whenever any sw_level bit changes.

Function
REQ-013 Each input bit SHALL pass through a two-flop synchronizer; key bits SHALL be inverted after synchronization, giving s = 1 when pressed.
REQ-014 Each bit SHALL own an independent counter of width clog2(CNT_MAX) and a registered stable level.
REQ-015 Per bit, per cycle: if s == stable, counter <= 0; else if counter == CNT_MAX-1, stable <= s and counter <= 0; else counter <= counter+1.
REQ-016 A single synchronized sample equal to stable SHALL reset that bit's counter to 0, so only CNT_MAX consecutive differing samples cause acceptance.
REQ-017 Latency SHALL be exactly 2 + CNT_MAX clock edges from a clean raw edge to the edge on which key_level/sw_level changes.
REQ-018 key_press/key_release/sw_change SHALL be registered and high during exactly the first cycle in which the new level is visible, then low.
REQ-019 Bits SHALL be fully independent; simultaneous acceptances on several bits SHALL assert all corresponding pulses in the same cycle, and sw_change SHALL still be one cycle wide.
REQ-020 Counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.
REQ-021 Raw glitches shorter than CNT_MAX cycles SHALL never alter any output.

Reset
REQ-022 While rst = 1: key synchronizer flops SHALL load 1 (released), sw synchronizer flops SHALL load 0, and all counters SHALL clear to 0.
REQ-023 While rst = 1: key_level = 0, sw_level = 0, key_press = 0, key_release = 0, sw_change = 0.
REQ-024 Reset asserted mid-count SHALL discard the partial count; after release, a held input SHALL be accepted 2 + CNT_MAX cycles later with its normal pulse.
REQ-025 No pulse SHALL be produced on the first cycle after reset deassertion.

Verification (CNT_MAX = 4, NKEY = 2, NSW = 10)
REQ-026 Reset, then key_n[0] 1->0 held -> key_level[0] rises on edge 6 after the change; key_press[0] high for exactly that cycle; key_n[1] unaffected.
REQ-027 key_n[0] low for 3 cycles, then high -> key_level[0] stays 0 and no pulses appear.
REQ-028 Pressed key_n[0] 0->1 held -> key_level[0] falls after 6 edges with one key_release[0] pulse.
REQ-029 sw 0x000->0x201 in one cycle -> sw_level = 0x201 after 6 edges; sw_change high for exactly 1 cycle.
REQ-030 sw[3] high 2 cycles, low 1, high 10 -> accepted 6 edges after the final rise; the interrupted run yields nothing.
REQ-031 key_n[1] held low, rst pulsed after 3 cycles of counting -> outputs 0 during rst; key_level[1] rises 6 edges after rst falls with one key_press[1] pulse.
